// File: rtl/pwm_multichannel_action_timer.sv
// Multichannel PWM timebase with shadowed period/mode/compare registers and
// per-channel action-qualified outputs (zero, period, compare A/B up/down).
module pwm_multichannel_action_timer #(
    parameter int WIDTH = 16,
    parameter int NCH   = 2
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_enable,
    input  logic                 i_mode,
    input  logic [WIDTH-1:0]     i_period,
    input  logic [NCH*WIDTH-1:0] i_compare_a,
    input  logic [NCH*WIDTH-1:0] i_compare_b,
    input  logic                 i_load_req,
    input  logic [2*NCH-1:0]     i_action_zero,
    input  logic [2*NCH-1:0]     i_action_period,
    input  logic [2*NCH-1:0]     i_action_a_up,
    input  logic [2*NCH-1:0]     i_action_a_down,
    input  logic [2*NCH-1:0]     i_action_b_up,
    input  logic [2*NCH-1:0]     i_action_b_down,
    output logic [WIDTH-1:0]     o_counter,
    output logic                 o_dir,
    output logic                 o_zero,
    output logic                 o_period,
    output logic [NCH-1:0]       o_pwm
);

    logic [WIDTH-1:0]     cnt, cnt_next;
    logic                 dir, dir_next;
    logic [NCH-1:0]       pwm, pwm_next;
    logic                 pending, load;
    logic [WIDTH-1:0]     per_act;
    logic                 mode_act;
    logic [NCH*WIDTH-1:0] cmp_a_act, cmp_b_act;
    logic [1:0]           act [NCH];

    logic at_zero, at_period;
    assign at_zero   = (cnt == '0);
    assign at_period = (cnt == per_act);
    assign load      = i_enable & pending & at_zero;

    // Per-channel event priority: zero > A > B > period; A/B pick the
    // up or down action field from the current direction.
    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic [WIDTH-1:0] ca, cb;
        logic             ev_a, ev_b;
        assign ca   = cmp_a_act[g*WIDTH +: WIDTH];
        assign cb   = cmp_b_act[g*WIDTH +: WIDTH];
        assign ev_a = (cnt == ca) && (ca <= per_act);
        assign ev_b = (cnt == cb) && (cb <= per_act);
        assign act[g] = at_zero   ? i_action_zero[2*g +: 2] :
                        ev_a      ? (dir ? i_action_a_up[2*g +: 2] : i_action_a_down[2*g +: 2]) :
                        ev_b      ? (dir ? i_action_b_up[2*g +: 2] : i_action_b_down[2*g +: 2]) :
                        at_period ? i_action_period[2*g +: 2] : 2'b00;
    end

    always_comb begin
        pwm_next = pwm;
        if (i_enable) begin
            for (int n = 0; n < NCH; n++) begin
                case (act[n])
                    2'b01:   pwm_next[n] = 1'b0;
                    2'b10:   pwm_next[n] = 1'b1;
                    2'b11:   pwm_next[n] = ~pwm[n];
                    default: pwm_next[n] = pwm[n];
                endcase
            end
        end
    end

    // A load edge restarts the timebase from the newly captured period.
    always_comb begin
        cnt_next = cnt;
        dir_next = dir;
        if (i_enable) begin
            if (load) begin
                cnt_next = (i_period != '0) ? WIDTH'(1) : '0;
                dir_next = 1'b1;
            end else if (per_act == '0) begin
                cnt_next = '0;
                dir_next = 1'b1;
            end else if (!mode_act) begin
                cnt_next = (cnt >= per_act) ? '0 : cnt + WIDTH'(1);
                dir_next = 1'b1;
            end else if (dir) begin
                if (cnt >= per_act) begin
                    cnt_next = per_act - WIDTH'(1);
                    dir_next = 1'b0;
                end else begin
                    cnt_next = cnt + WIDTH'(1);
                end
            end else begin
                if (at_zero) begin
                    cnt_next = WIDTH'(1);
                    dir_next = 1'b1;
                end else begin
                    cnt_next = cnt - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            cnt       <= '0;
            dir       <= 1'b1;
            pwm       <= '0;
            pending   <= 1'b1;
            per_act   <= '0;
            mode_act  <= 1'b0;
            cmp_a_act <= '0;
            cmp_b_act <= '0;
        end else begin
            cnt     <= cnt_next;
            dir     <= dir_next;
            pwm     <= pwm_next;
            pending <= i_load_req | (pending & ~load);
            if (load) begin
                per_act   <= i_period;
                mode_act  <= i_mode;
                cmp_a_act <= i_compare_a;
                cmp_b_act <= i_compare_b;
            end
        end
    end

    assign o_counter = cnt;
    assign o_dir     = dir;
    assign o_pwm     = pwm;
    assign o_zero    = i_enable & at_zero;
    assign o_period  = i_enable & at_period;

endmodule

// File: tb/tb_pwm_multichannel_action_timer.sv
// Randomized bench for pwm_multichannel_action_timer against a phase-based
// reference model, plus directed duty, shadow, priority, freeze and reset scenarios.
module tb_pwm_multichannel_action_timer;
    localparam int WIDTH = 16;
    localparam int NCH   = 2;
    localparam int EW    = WIDTH + 3 + NCH;

    logic                 clk, rst_n, en, mode, load_req;
    logic [WIDTH-1:0]     period;
    logic [NCH*WIDTH-1:0] cmp_a, cmp_b;
    logic [2*NCH-1:0]     az, ap, aau, aad, abu, abd;
    logic [WIDTH-1:0]     counter;
    logic                 dir, zero, per_evt;
    logic [NCH-1:0]       pwm;

    pwm_multichannel_action_timer #(.WIDTH(WIDTH), .NCH(NCH)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_enable(en), .i_mode(mode),
        .i_period(period), .i_compare_a(cmp_a), .i_compare_b(cmp_b),
        .i_load_req(load_req), .i_action_zero(az), .i_action_period(ap),
        .i_action_a_up(aau), .i_action_a_down(aad),
        .i_action_b_up(abu), .i_action_b_down(abd),
        .o_counter(counter), .o_dir(dir), .o_zero(zero),
        .o_period(per_evt), .o_pwm(pwm)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [EW-1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: position within the period (phase) rather than a counter.
    int m_t, m_per, m_ca[NCH], m_cb[NCH];
    bit m_fresh, m_mode, m_pend;
    bit [NCH-1:0] m_pwm;

    function automatic int model_c();
        if (m_mode && m_t > m_per) return 2*m_per - m_t;
        return m_t;
    endfunction

    function automatic bit model_dir();
        if (!m_mode || m_per == 0) return 1'b1;
        if (m_t == 0) return m_fresh;
        return (m_t <= m_per);
    endfunction

    function automatic logic [1:0] pick(input int n, input int c, input bit d);
        logic [2*NCH-1:0] a_sel, b_sel;
        a_sel = d ? aau : aad;
        b_sel = d ? abu : abd;
        if (c == 0) return az[2*n +: 2];
        if (m_ca[n] == c && m_ca[n] <= m_per) return a_sel[2*n +: 2];
        if (m_cb[n] == c && m_cb[n] <= m_per) return b_sel[2*n +: 2];
        if (c == m_per) return ap[2*n +: 2];
        return 2'b00;
    endfunction

    task automatic model_step();
        int c; bit d, ld;
        logic [1:0] code;
        if (!rst_n) begin
            m_t = 0; m_fresh = 1; m_pwm = '0; m_per = 0; m_mode = 0; m_pend = 1;
            for (int n = 0; n < NCH; n++) begin m_ca[n] = 0; m_cb[n] = 0; end
            return;
        end
        c  = model_c();
        d  = model_dir();
        ld = en && m_pend && (c == 0);
        if (en) begin
            for (int n = 0; n < NCH; n++) begin
                code = pick(n, c, d);
                case (code)
                    2'b01: m_pwm[n] = 1'b0;
                    2'b10: m_pwm[n] = 1'b1;
                    2'b11: m_pwm[n] = ~m_pwm[n];
                    default: ;
                endcase
            end
        end
        m_pend = load_req || (m_pend && !ld);
        if (en) begin
            if (ld) begin
                m_per = int'(period); m_mode = mode;
                for (int n = 0; n < NCH; n++) begin
                    m_ca[n] = int'(cmp_a[n*WIDTH +: WIDTH]);
                    m_cb[n] = int'(cmp_b[n*WIDTH +: WIDTH]);
                end
                m_t = (m_per > 0) ? 1 : 0;
                m_fresh = 1;
            end else if (m_per == 0) begin
                m_t = 0;
            end else if (!m_mode) begin
                m_t = (m_t + 1) % (m_per + 1);
            end else begin
                m_t = (m_t + 1) % (2*m_per);
                if (m_t == 0) m_fresh = 0;
            end
        end
    endtask

    // One clock: model and DUT see the same inputs at the edge, compare at +1.
    task automatic cycle();
        logic [EW-1:0] e;
        int c;
        @(posedge clk);
        model_step();
        c = model_c();
        exp_q.push_back({WIDTH'(c), model_dir(), en && (c == 0), en && (c == m_per), m_pwm});
        #1;
        e = exp_q.pop_front();
        check_eq("counter", 32'(counter), 32'(e[EW-1 -: WIDTH]));
        check_eq("dir",     32'(dir),     32'(e[NCH+2]));
        check_eq("zero",    32'(zero),    32'(e[NCH+1]));
        check_eq("period",  32'(per_evt), 32'(e[NCH]));
        check_eq("pwm",     32'(pwm),     32'(e[NCH-1:0]));
    endtask

    task automatic set_ch0(input logic [1:0] z, input logic [1:0] pe, input logic [1:0] au,
                           input logic [1:0] ad, input logic [1:0] bu, input logic [1:0] bd);
        az = '0; ap = '0; aau = '0; aad = '0; abu = '0; abd = '0;
        az[1:0] = z; ap[1:0] = pe; aau[1:0] = au; aad[1:0] = ad; abu[1:0] = bu; abd[1:0] = bd;
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        cycle();
        load_req = 1'b0;
    endtask

    task automatic wait_counter(input int v);
        int k = 0;
        while (int'(counter) != v && k < 60) begin cycle(); k++; end
        if (int'(counter) != v) check_eq("wait_counter", 32'(counter), 32'(v));
    endtask

    task automatic drive_random();
        rst_n    = ($urandom_range(0, 299) != 0);
        en       = ($urandom_range(0, 9) != 0);
        load_req = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 39) == 0) begin
            period = WIDTH'($urandom_range(0, 12));
            mode   = 1'($urandom_range(0, 1));
            for (int n = 0; n < NCH; n++) begin
                cmp_a[n*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 14));
                cmp_b[n*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 14));
            end
        end
        if ($urandom_range(0, 19) == 0) begin
            az  = (2*NCH)'($urandom); ap  = (2*NCH)'($urandom);
            aau = (2*NCH)'($urandom); aad = (2*NCH)'($urandom);
            abu = (2*NCH)'($urandom); abd = (2*NCH)'($urandom);
        end
    endtask

    int hi, rise_a, rise_b;
    logic prev;

    initial begin
        rst_n = 0; en = 0; mode = 0; load_req = 0; period = '0;
        cmp_a = '0; cmp_b = '0;
        set_ch0(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        repeat (3) cycle();
        check_eq("rst_counter", 32'(counter), 0);
        check_eq("rst_dir", 32'(dir), 1);
        check_eq("rst_pwm", 32'(pwm), 0);
        rst_n = 1;

        // Up count P=9, A0=4: set at zero, clear at A -> period 10
        period = 16'd9; mode = 0; cmp_a[WIDTH-1:0] = 16'd4;
        set_ch0(2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
        en = 1;
        pulse_load();
        repeat (20) cycle();
        rise_a = -1; rise_b = -1; prev = pwm[0];
        for (int i = 0; i < 25; i++) begin
            cycle();
            if (pwm[0] && !prev) begin
                if (rise_a < 0) rise_a = i; else if (rise_b < 0) rise_b = i;
            end
            prev = pwm[0];
        end
        check_eq("up_pwm_period", 32'(rise_b - rise_a), 10);

        // Shadow: new A0 only takes effect after the next zero load
        wait_counter(5);
        cmp_a[WIDTH-1:0] = 16'd7;
        pulse_load();
        repeat (30) cycle();

        // Up-down P=4, A0=2: clear going up, set going down -> 4 of 8 high
        mode = 1; period = 16'd4; cmp_a[WIDTH-1:0] = 16'd2;
        set_ch0(2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00);
        pulse_load();
        repeat (30) cycle();
        hi = 0;
        for (int i = 0; i < 8; i++) begin cycle(); hi += int'(pwm[0]); end
        check_eq("updown_duty", 32'(hi), 4);

        // Priority: zero beats A at C==0
        mode = 0; period = 16'd9; cmp_a[WIDTH-1:0] = 16'd0; cmp_b[WIDTH-1:0] = 16'd3;
        set_ch0(2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
        pulse_load();
        repeat (25) cycle();
        check_eq("prio_zero_over_a", 32'(pwm[0]), 1);
        // A beats B when both match
        cmp_a[WIDTH-1:0] = 16'd3;
        set_ch0(2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00);
        pulse_load();
        repeat (12) cycle();
        wait_counter(6);
        check_eq("prio_a_over_b", 32'(pwm[0]), 1);

        // Freeze at C==6 for 3 cycles
        en = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_eq("freeze_counter", 32'(counter), 6);
            check_eq("freeze_pwm", 32'(pwm[0]), 1);
        end
        en = 1;
        cycle();
        check_eq("resume_counter", 32'(counter), 7);

        // Reset mid-period, pending reload at first zero
        wait_counter(5);
        rst_n = 0;
        cycle();
        check_eq("midrst_counter", 32'(counter), 0);
        check_eq("midrst_pwm", 32'(pwm), 0);
        check_eq("midrst_dir", 32'(dir), 1);
        rst_n = 1;
        repeat (15) cycle();

        for (int i = 0; i < 3000; i++) begin
            drive_random();
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
